vpu_stream_sched: RTL and testbench

Sequencer that streams a programmed window of VPU memory words into the tensor datapath.
- Word fields: valid flag, tensors, channel address, Tmax.
- Issues reads to a synchronous memory with 1-cycle read latency.
- Unpacks each word and presents it over a valid/ready handshake, with a 2-entry output buffer absorbing backpressure.
- Sits between the VPU word memory (memory now addressed, not free-running) and the downstream PE/tensor consumer.

---
 rtl/vpu_pkg.sv | 16 +
 rtl/vpu_skid_fifo.sv | 56 +++++
 rtl/vpu_stream_sched.sv | 132 +++++++++++++
 tb/tb_vpu_stream_sched.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_pkg.sv
// Field offsets of a VPU memory word and the sequencer state encoding.
package vpu_pkg;

  localparam int VPU_VALID_BIT = 1056;
  localparam int VPU_TENS_MSB  = 1055;
  localparam int VPU_TENS_LSB  = 32;
  localparam int VPU_CHN_LSB   = 16;
  localparam int VPU_TMAX_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } vpu_state_e;

endpackage

// File: rtl/vpu_skid_fifo.sv
// Two-entry register FIFO holding unpacked VPU words.
// Latency: a pushed word is at the head on the next cycle.
// Backpressure: full when two entries are held; push+pop together is legal even when full.
module vpu_skid_fifo #(
  parameter int WIDTH = 1056
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_idx;
  logic             rd_idx;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      count  <= 2'd0;
    end else begin
      wr_idx <= wr_idx ^ push_ok;
      rd_idx <= rd_idx ^ pop_ok;
      count  <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  // Payload storage needs no reset; the head is only looked at when not empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_idx] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && !flush) begin
      assert (!(push && full && !pop));
    end
  end

endmodule

// File: rtl/vpu_stream_sched.sv
// Streams a window of VPU memory words to the tensor datapath over valid/ready.
// Latency: first word at out_valid two cycles after start is sampled; 1 word/cycle sustained.
// Backpressure: reads are only issued while buffered plus in-flight words stay within two.
module vpu_stream_sched
  import vpu_pkg::*;
#(
  parameter int DATA_WIDTH    = 1057,
  parameter int MEM_ADDR_SIZE = 5,
  parameter int TENSOR_W      = 1024
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [MEM_ADDR_SIZE-1:0] base_addr,
  input  logic [MEM_ADDR_SIZE:0]   num_words,
  input  logic                     abort,
  output logic                     mem_en,
  output logic [MEM_ADDR_SIZE-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_chnaddr,
  output logic [15:0]              out_tmax,
  output logic [TENSOR_W-1:0]      out_tensors,
  output logic                     busy,
  output logic                     done
);

  localparam int EW = DATA_WIDTH - 1;

  vpu_state_e               state;
  vpu_state_e               state_nxt;
  logic [MEM_ADDR_SIZE-1:0] rd_ptr;
  logic [MEM_ADDR_SIZE:0]   remaining;
  logic                     inflight;
  logic                     done_r;
  logic                     done_set;
  logic                     issue;
  logic                     push;
  logic                     pop;
  logic [1:0]               count;
  logic [1:0]               pending;
  logic                     full;
  logic                     empty;
  logic [EW-1:0]            head;

  assign pending = count + {1'b0, inflight};
  assign pop     = out_valid & out_ready;
  // An invalid word still consumed a read slot; it simply never enters the buffer.
  assign push    = inflight & mem_rdata[VPU_VALID_BIT] & ~abort;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    done_set  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            state_nxt = RUN;
          end else begin
            done_set = 1'b1;
          end
        end
      end
      RUN: begin
        issue = (pending < 2'd2) || ((pending == 2'd2) && pop);
        if (issue && (remaining == (MEM_ADDR_SIZE+1)'(1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight && empty) begin
          state_nxt = IDLE;
          done_set  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      issue     = 1'b0;
      done_set  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      done_r   <= done_set;
      if ((state == IDLE) && start && !abort) begin
        rd_ptr    <= base_addr;
        remaining <= num_words;
      end else if (issue) begin
        rd_ptr    <= rd_ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  vpu_skid_fifo #(
    .WIDTH(EW)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .flush(abort),
    .push (push),
    .din  (mem_rdata[VPU_TENS_MSB:VPU_TMAX_LSB]),
    .pop  (pop),
    .dout (head),
    .full (full),
    .empty(empty),
    .count(count)
  );

  assign mem_en      = issue;
  assign mem_addr    = issue ? rd_ptr : '0;
  assign busy        = (state != IDLE);
  assign done        = done_r;
  assign out_valid   = ~empty;
  assign out_chnaddr = empty ? 16'd0 : head[VPU_CHN_LSB+15:VPU_CHN_LSB];
  assign out_tmax    = empty ? 16'd0 : head[VPU_TMAX_LSB+15:VPU_TMAX_LSB];
  assign out_tensors = empty ? '0 : head[VPU_TENS_MSB:VPU_TENS_LSB];

endmodule

// File: tb/tb_vpu_stream_sched.sv
// Scoreboard bench for vpu_stream_sched with a synchronous 32-word memory model.
module tb_vpu_stream_sched;

  localparam int DW    = 1057;
  localparam int AW    = 5;
  localparam int TW    = 1024;
  localparam int DEPTH = 32;

  logic            clk = 1'b0;
  logic            rstn;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [AW:0]     num_words;
  logic            abort;
  logic            mem_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_rdata = '0;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_chnaddr;
  logic [15:0]     out_tmax;
  logic [TW-1:0]   out_tensors;
  logic            busy;
  logic            done;

  logic [DW-1:0]   tmem [DEPTH];
  logic [AW-1:0]   addr_q [$];
  logic [DW-2:0]   exp_q [$];

  int n_chk = 0, n_fail = 0;
  int n_pop, n_issue, n_drop, n_done, max_pend;
  int first_issue, last_issue, first_pop, last_pop;
  int cyc = 0;
  logic          prev_en = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [15:0]   hold_chn, hold_tmax;
  logic [255:0]  hold_tens;

  vpu_stream_sched #(
    .DATA_WIDTH(DW), .MEM_ADDR_SIZE(AW), .TENSOR_W(TW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
    .num_words(num_words), .abort(abort), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_chnaddr(out_chnaddr), .out_tmax(out_tmax), .out_tensors(out_tensors),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) mem_rdata <= tmem[mem_addr];
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mk_word(input int a, input bit v, input int tag);
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < 32; k++) w[32+k*32 +: 32] = {a[7:0], k[7:0], tag[7:0], 8'h5A};
    w[31:16] = 16'hC000 | 16'(a * 16 + tag);
    w[15:0]  = 16'(a * 7 + tag * 131 + 1);
    w[DW-1]  = v;
    return w;
  endfunction

  task automatic fill(input int tag);
    for (int a = 0; a < DEPTH; a++) tmem[a] = mk_word(a, 1'b1, tag);
  endtask

  // Monitor: compares reads and outputs against the scoreboard queues.
  always @(negedge clk) begin
    if (rstn !== 1'b1) begin
      prev_en = 1'b0;
    end else begin
      if (prev_en && !tmem[prev_addr][DW-1]) n_drop++;
      if (mem_en) begin
        if (addr_q.size() == 0) chk("unexpected_read", mem_en, 0);
        else chk("mem_addr", mem_addr, addr_q.pop_front());
        if (first_issue < 0) first_issue = cyc;
        last_issue = cyc;
        n_issue++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", out_valid, 0);
        else begin
          logic [DW-2:0] e;
          e = exp_q.pop_front();
          chk("out_chnaddr", out_chnaddr, e[31:16]);
          chk("out_tmax", out_tmax, e[15:0]);
          for (int c = 0; c < 4; c++) chk("out_tensors", out_tensors[c*256 +: 256], e[32+c*256 +: 256]);
        end
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        n_pop++;
      end
      if (done) begin
        n_done++;
        chk("busy_at_done", busy, 0);
      end
      if (n_issue - n_pop - n_drop > max_pend) max_pend = n_issue - n_pop - n_drop;
      prev_en   = mem_en;
      prev_addr = mem_addr;
    end
  end

  task automatic start_job(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = AW'((base + i) % DEPTH);
      addr_q.push_back(a);
      if (tmem[a][DW-1]) exp_q.push_back(tmem[a][DW-2:0]);
    end
    n_pop = 0; n_issue = 0; n_drop = 0; n_done = 0; max_pend = 0;
    first_issue = -1; last_issue = -1; first_pop = -1; last_pop = -1;
    base_addr = AW'(base);
    num_words = (AW+1)'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin @(posedge clk); #1; k++; end
    if (busy) chk("idle_timeout", busy, 0);
    @(negedge clk); @(posedge clk); #1;
  endtask

  task automatic wait_pops(input int n, input int budget);
    int k = 0;
    while (n_pop < n && k < budget) begin @(posedge clk); k++; end
    if (n_pop < n) chk("pop_timeout", n_pop, n);
    #1;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    base_addr = '0; num_words = '0;
    fill(1);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fields", {out_chnaddr, out_tmax}, 0);
    @(posedge clk); #1;

    // 1: contiguous window, full throughput
    start_job(4, 6);
    wait_idle(100);
    chk("t1_pops", n_pop, 6);
    chk("t1_done", n_done, 1);
    chk("t1_read_span", last_issue - first_issue, 5);
    chk("t1_out_span", last_pop - first_pop, 5);
    chk("t1_busy", busy, 0);

    // 2: address wrap
    fill(2);
    start_job(30, 4);
    wait_idle(100);
    chk("t2_pops", n_pop, 4);
    chk("t2_left", exp_q.size(), 0);
    chk("t2_done", n_done, 1);

    // 3: invalid words dropped
    fill(3);
    tmem[11] = mk_word(11, 1'b0, 3);
    tmem[13] = mk_word(13, 1'b0, 3);
    start_job(10, 5);
    wait_idle(100);
    chk("t3_pops", n_pop, 3);
    chk("t3_reads", n_issue, 5);
    chk("t3_done", n_done, 1);

    // 4: backpressure stall
    fill(4);
    start_job(0, 12);
    wait_pops(3, 50);
    out_ready = 1'b0;
    @(negedge clk);
    chk("t4_stall_valid", out_valid, 1);
    hold_chn = out_chnaddr; hold_tmax = out_tmax; hold_tens = out_tensors[255:0];
    repeat (10) @(negedge clk);
    chk("t4_hold_chn", out_chnaddr, hold_chn);
    chk("t4_hold_tmax", out_tmax, hold_tmax);
    chk("t4_hold_tens", out_tensors[255:0], hold_tens);
    chk("t4_hold_valid", out_valid, 1);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle(100);
    chk("t4_pops", n_pop, 12);
    chk("t4_pending_le2", max_pend <= 2, 1);
    chk("t4_done", n_done, 1);

    // 5: abort mid-job, then a clean job
    fill(5);
    start_job(8, 8);
    wait_pops(2, 50);
    abort = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1 abort = 1'b0;
    addr_q.delete(); exp_q.delete();
    @(negedge clk);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_mem_en", mem_en, 0);
    chk("t5_busy", busy, 0);
    repeat (5) @(posedge clk);
    #1 chk("t5_no_done", n_done, 0);
    out_ready = 1'b1;
    start_job(20, 3);
    wait_idle(100);
    chk("t5_new_pops", n_pop, 3);
    chk("t5_new_done", n_done, 1);

    // 6a: zero-length job
    start_job(5, 0);
    @(negedge clk);
    chk("t6_zero_done", done, 1);
    chk("t6_zero_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 chk("t6_zero_reads", n_issue, 0);
    chk("t6_zero_done_cnt", n_done, 1);

    // 6b: start while busy is ignored
    fill(6);
    start_job(16, 8);
    repeat (2) @(posedge clk);
    #1 base_addr = '0; num_words = 7'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle(100);
    chk("t6_busy_pops", n_pop, 8);
    chk("t6_busy_done", n_done, 1);

    // 6c: reset mid-job
    fill(7);
    out_ready = 1'b0;
    start_job(0, 10);
    repeat (5) @(negedge clk);
    chk("t6_pre_rst_valid", out_valid, 1);
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    addr_q.delete(); exp_q.delete();
    @(negedge clk);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_mem_en", mem_en, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_fields", {out_chnaddr, out_tmax}, 0);
    chk("t6_rst_tens", out_tensors[255:0], 0);
    @(posedge clk); #1 out_ready = 1'b1;
    start_job(3, 2);
    wait_idle(100);
    chk("t6_after_rst_pops", n_pop, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
